// File: rtl/hamsi_host_sequencer.sv
// hamsi_host_sequencer
//   Drives one complete HAMSI hash through the core's init/load/fetch/ack
//   command port. A host start pulse triggers this sequence:
//     1. init the core;
//     2. stream nblocks*WORDS_PER_BLOCK message words from a valid/ready
//        source into the core;
//     3. fetch DIGEST_WORDS digest words and emit them on a valid/ready sink.
//   Every load and every fetch has an ack timeout. When it expires, the
//   sequencer abandons the hash and raises a sticky err.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, nblocks      hash request (sampled only when idle), block count
//   busy, done, err     status: not idle / end-of-hash pulse / sticky timeout
//   s_data/s_valid/s_ready   message word source
//   m_data/m_valid/m_ready   digest word sink
//   core_init/load/fetch, core_idata   commands and load data to the core
//   core_ack, core_odata               handshake and fetch data from the core
module hamsi_host_sequencer #(
  parameter int IOSIZE          = 16,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int DIGEST_WORDS    = 16,
  parameter int TIMEOUT         = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       nblocks,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [IOSIZE-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [IOSIZE-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              core_init,
  output logic              core_load,
  output logic              core_fetch,
  output logic [IOSIZE-1:0] core_idata,
  input  logic              core_ack,
  input  logic [IOSIZE-1:0] core_odata
);

  // The word counter is sized so that nblocks*WORDS_PER_BLOCK never wraps.
  // With nblocks = 16'hFFFF and two words per block, the count is 131070.
  localparam int CNT_W = 16 + $clog2(WORDS_PER_BLOCK);
  localparam int DIG_W = $clog2(DIGEST_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LGET,
    S_LREQ,
    S_FREQ,
    S_OUT,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // message words still to load
  logic [DIG_W-1:0]  dig_q, dig_d;       // digest words already emitted
  logic [TMO_W-1:0]  wait_q, wait_d;     // cycles spent waiting for ack
  logic [IOSIZE-1:0] hold_q, hold_d;     // message word being loaded
  logic [IOSIZE-1:0] mdata_q, mdata_d;   // digest word being offered
  logic              err_q, err_d;
  logic              done_q, done_d;

  // Two cycles before the terminal count means this non-acked cycle is the
  // last one allowed. An ack in the same cycle still takes priority.
  logic tmo_hit;
  assign tmo_hit = (wait_q == TMO_W'(TIMEOUT - 2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    wait_d  = '0;
    hold_d  = hold_q;
    mdata_d = mdata_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = CNT_W'(nblocks) * CNT_W'(WORDS_PER_BLOCK);
          dig_d   = '0;
          err_d   = 1'b0;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        state_d = (cnt_q != '0) ? S_LGET : S_FREQ;
      end

      S_LGET: begin
        if (s_valid) begin
          hold_d  = s_data;
          state_d = S_LREQ;
        end
      end

      S_LREQ: begin
        if (core_ack) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? S_FREQ : S_LGET;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_q + TMO_W'(1);
        end
      end

      S_FREQ: begin
        if (core_ack) begin
          mdata_d = core_odata;
          state_d = S_OUT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_q + TMO_W'(1);
        end
      end

      S_OUT: begin
        if (m_ready) begin
          dig_d = dig_q + DIG_W'(1);
          if (dig_q == DIG_W'(DIGEST_WORDS - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FREQ;
          end
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      mdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // All strobes are decoded from the state register alone.
  // Because of this, load and fetch drop in the cycle after the ack.
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign s_ready    = (state_q == S_LGET);
  assign m_valid    = (state_q == S_OUT);
  assign m_data     = mdata_q;
  assign core_init  = (state_q == S_INIT);
  assign core_load  = (state_q == S_LREQ);
  assign core_fetch = (state_q == S_FREQ);
  assign core_idata = hold_q;

endmodule

// File: tb/tb_hamsi_host_sequencer.sv
// Bench for hamsi_host_sequencer.
// It contains a small core model that acks each request on its second cycle
// and returns 0,1,2,... as digest words. It also has a message source with an
// optional gap between words and a sink that is always ready or toggles.
// Load data and digest words are pushed to scoreboards when driven, and are
// compared when the DUT hands them over.
module tb_hamsi_host_sequencer;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] nblocks = '0;
  logic        busy, done, err;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        core_init, core_load, core_fetch;
  logic [15:0] core_idata;
  logic        core_ack = 1'b0;
  logic [15:0] core_odata = '0;

  always #5 clk = ~clk;

  hamsi_host_sequencer #(
    .IOSIZE(16), .WORDS_PER_BLOCK(2), .DIGEST_WORDS(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .nblocks(nblocks),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_init(core_init), .core_load(core_load), .core_fetch(core_fetch),
    .core_idata(core_idata), .core_ack(core_ack), .core_odata(core_odata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench state
  logic [15:0] src_q[$];
  logic [15:0] exp_load[$];
  logic [15:0] exp_m[$];
  int          src_gap = 0;
  int          gap_cnt = 0;
  bit          src_pend = 0;
  int          ack_mode = 0;     // 0 normal, 1 never ack loads, 2 spurious acks in LGET
  bit          sink_toggle = 0;
  int          req_age = 0;
  logic [15:0] fetch_idx = '0;
  bit          m_stall_prev = 0;
  logic [15:0] m_data_prev = '0;
  int init_cnt, load_hi_cnt, srdy_cnt, done_cnt, load_ack_cnt, fetch_ack_cnt, m_hs_cnt;

  task automatic clr_cnt();
    init_cnt = 0; load_hi_cnt = 0; srdy_cnt = 0; done_cnt = 0;
    load_ack_cnt = 0; fetch_ack_cnt = 0; m_hs_cnt = 0;
  endtask

  // Each negedge: drive the inputs for the next posedge, then check the
  // handshakes that posedge will complete.
  initial begin
    clr_cnt();
    forever begin
      @(negedge clk);
      // source
      if (src_pend && src_q.size() > 0) begin
        src_q.delete(0);
        gap_cnt = src_gap;
      end
      src_pend = 0;
      if (src_q.size() > 0 && gap_cnt == 0) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
        if (gap_cnt > 0) gap_cnt--;
      end
      // sink
      m_ready = sink_toggle ? ~m_ready : 1'b1;
      // core model
      core_ack = 1'b0;
      if (core_init) fetch_idx = '0;
      if ((core_load && ack_mode != 1) || core_fetch) begin
        req_age++;
        if (req_age >= 2) begin
          core_ack = 1'b1;
          req_age  = 0;
          if (core_fetch) begin
            core_odata = fetch_idx;
            exp_m.push_back(fetch_idx);
            fetch_idx++;
          end
        end
      end else begin
        req_age = 0;
        if (ack_mode == 2 && s_ready) core_ack = 1'b1;
      end
      // monitor
      if (core_init) init_cnt++;
      if (core_load) load_hi_cnt++;
      if (s_ready)   srdy_cnt++;
      if (done)      done_cnt++;
      if (s_valid && s_ready) begin
        src_pend = 1;
        exp_load.push_back(s_data);
      end
      if (core_load && core_ack) begin
        load_ack_cnt++;
        if (exp_load.size() == 0) chk("load_extra", 0, 1);
        else chk("load_idata", core_idata, exp_load.pop_front());
      end
      if (core_fetch && core_ack) fetch_ack_cnt++;
      if (m_stall_prev) begin
        chk("m_hold_valid", m_valid, 1);
        chk("m_hold_data", m_data, m_data_prev);
      end
      if (m_valid && m_ready) begin
        m_hs_cnt++;
        if (exp_m.size() == 0) chk("m_extra", 0, 1);
        else chk("m_data", m_data, exp_m.pop_front());
      end
      m_stall_prev = m_valid && !m_ready;
      m_data_prev  = m_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Start one hash and follow it to its done pulse, then check the totals.
  task automatic run_hash(input logic [15:0] nb, input bit hold, input string tag);
    bit got;
    clr_cnt();
    nblocks = nb;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk({tag, "_init_lat"}, core_init, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_err_clr"}, err, 0);
    tick();
    chk({tag, "_init_1cyc"}, core_init, 0);
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_init_cnt"}, init_cnt, 1);
    chk({tag, "_loads"}, load_ack_cnt, 2 * nb);
    chk({tag, "_fetches"}, fetch_ack_cnt, 16);
    chk({tag, "_m_words"}, m_hs_cnt, 16);
    chk({tag, "_load_q"}, exp_load.size(), 0);
    chk({tag, "_m_q"}, exp_m.size(), 0);
    chk({tag, "_src_q"}, src_q.size(), 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    bit got;
    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_strobes", {core_init, core_load, core_fetch}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_idata", core_idata, 0);
    rst = 1'b0;
    tick();

    // single block, fast source and sink
    src_q.push_back(16'h1234);
    src_q.push_back(16'h5678);
    run_hash(16'd1, 0, "t1");

    // no message blocks: straight to fetching
    run_hash(16'd0, 0, "t2");
    chk("t2_no_s_ready", srdy_cnt, 0);

    // stalled source, toggling sink
    src_gap = 10;
    sink_toggle = 1;
    for (int i = 0; i < 6; i++) src_q.push_back(16'hA000 + 16'(i * 17));
    run_hash(16'd3, 0, "t3");
    src_gap = 0;
    sink_toggle = 0;
    tick();

    // load never acked -> timeout
    clr_cnt();
    ack_mode = 1;
    src_q.push_back(16'hBEEF);
    nblocks = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (err) begin
        got = 1;
        break;
      end
    end
    chk("t4_err_seen", got, 1);
    chk("t4_err_busy", busy, 1);
    chk("t4_err_strobes", {core_init, core_load, core_fetch}, 0);
    chk("t4_load_cycles", load_hi_cnt, TMO - 1);
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_err_sticky", err, 1);
    tick();
    tick();
    chk("t4_err_sticky2", err, 1);
    ack_mode = 0;
    exp_load.delete();
    src_q.push_back(16'h0F0F);
    src_q.push_back(16'hF0F0);
    run_hash(16'd1, 0, "t4b");

    // start held high while busy, spurious acks while waiting for source
    ack_mode = 2;
    src_gap = 3;
    for (int i = 0; i < 4; i++) src_q.push_back(16'h3C00 | 16'(i));
    run_hash(16'd2, 1, "t5");
    ack_mode = 0;
    src_gap = 0;

    // reset in the middle of the digest phase
    clr_cnt();
    src_q.push_back(16'h1111);
    src_q.push_back(16'h2222);
    nblocks = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (m_hs_cnt >= 5 && core_fetch) begin
        got = 1;
        break;
      end
    end
    chk("t6_reached", got, 1);
    rst = 1'b1;
    tick();
    chk("t6_strobes", {core_init, core_load, core_fetch}, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    rst = 1'b0;
    exp_m.delete();
    exp_load.delete();
    tick();
    src_q.push_back(16'h3333);
    src_q.push_back(16'h4444);
    run_hash(16'd1, 0, "t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamsi_host_sequencer.md
Name: hamsi_host_sequencer

Overview:
- Sequences one complete HAMSI hash on HAMSI_TOP's init/load/fetch/ack port.
- On a host `start`, issues init, streams nblocks*WORDS_PER_BLOCK message words from a valid/ready source, then fetches DIGEST_WORDS digest words and emits them on a valid/ready sink.
- Sits between the system-side host/DMA and the HAMSI_TOP core.
- Replaces the bench-driven command sequencing; includes a per-transfer ack timeout.

Parameters:
- IOSIZE, 16: width of core idata/odata and of stream data.
- WORDS_PER_BLOCK, 2: IOSIZE words per message block (32-bit HAMSI-256 block).
- DIGEST_WORDS, 16: IOSIZE words fetched per digest (256 bits).
- TIMEOUT, 1024: maximum cycles to wait for core_ack on one load/fetch.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a hash; sampled only in IDLE.
- nblocks  in  16  number of message blocks; latched with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last digest word is accepted by sink.
- err  out  1  sticky timeout flag; cleared by rst or next accepted start.
- s_data  in  IOSIZE  message word.
- s_valid  in  1  message word valid.
- s_ready  out  1  message word accepted this cycle (s_valid & s_ready).
- m_data  out  IOSIZE  digest word.
- m_valid  out  1  digest word valid.
- m_ready  in  1  sink accepts digest word.
- core_init  out  1  to HAMSI_TOP init.
- core_load  out  1  to HAMSI_TOP load.
- core_fetch  out  1  to HAMSI_TOP fetch.
- core_idata  out  IOSIZE  to HAMSI_TOP idata.
- core_ack  in  1  from HAMSI_TOP ack.
- core_odata  in  IOSIZE  from HAMSI_TOP odata.

Behaviour:
- Reset: state=IDLE; all outputs 0 (busy, done, err, s_ready, m_valid, core_init, core_load, core_fetch); m_data=0; core_idata=0; counters=0.
- States: IDLE, INIT, LGET, LREQ, FREQ, OUT, ERR.
- IDLE:
  - start=1 latches nblocks into blk_remaining, sets word count total = nblocks*WORDS_PER_BLOCK (17-bit counter), clears err, goes to INIT.
  - Latency: start sampled at edge N -> core_init=1 during cycle N+1.
- INIT:
  - core_init=1 for exactly one cycle.
  - Next state is LGET if total!=0, else FREQ.
- LGET:
  - s_ready=1.
  - On s_valid, capture s_data into hold register and go to LREQ.
  - s_ready=0 in all other states; no word is taken until the previous word is acked.
- LREQ:
  - core_load=1; core_idata=hold, stable until ack.
  - On core_ack=1 at an edge: word transferred; decrement count.
  - Count reaching 0 -> FREQ, else -> LGET.
  - core_load drops in the cycle after ack (never held across words).
- FREQ:
  - core_fetch=1 until core_ack.
  - On ack, capture core_odata into m_data and go to OUT.
- OUT:
  - m_valid=1, m_data stable until m_ready.
  - On m_valid & m_ready: if DIGEST_WORDS words emitted -> IDLE with done=1 for that single cycle; else -> FREQ.
- Timeout:
  - Wait counter clears on entering LREQ/FREQ and increments each cycle core_ack=0 there.
  - Reaching TIMEOUT-1 without ack -> ERR.
  - ERR: all core_* strobes 0, err=1, busy=1 for one cycle, then IDLE with err held.
  - Source/sink stalls (s_valid, m_ready low) never time out.
- Simultaneous events:
  - start while busy is ignored.
  - core_ack in LGET/OUT/INIT/IDLE is ignored.
  - core_ack on the same edge as the timeout is taken as success (ack wins).
- Reset mid-operation returns to IDLE next edge with all strobes low; no partial done/err.
- Width: count wraps never; nblocks=16'hFFFF gives 131070 words.

Test Plan:
- rst, start with nblocks=1, core model acks every request after 2 cycles, source words 16'h1234,16'h5678, sink m_ready=1 -> core_init 1 cycle at N+1; two loads with idata 1234 then 5678; 16 fetches; m_data matches core_odata sequence 0x0000..0x000F; done pulses once; busy low after.
- nblocks=0 -> INIT then directly 16 fetches, no s_ready ever asserted, done pulses.
- Source stalls 10 cycles between words and sink m_ready toggles 1/0 -> no timeout, word order preserved, m_data stable while m_valid & !m_ready.
- Core never acks a load (TIMEOUT=8) -> core_load high 7 cycles, then ERR; err=1 sticky; busy returns 0; next start clears err.
- start held high during busy, plus core_ack pulses in LGET -> no restart and no extra word counted; exactly nblocks*2 loads.
- rst asserted in FREQ after 5 digest words -> next cycle all core strobes, m_valid, busy 0; a new start runs a full clean hash.
